// File: rtl/result_drain_pkg.sv
// Shared sizing defaults and FSM state encoding for the result drain block.
// Imported by the interface, the storage sub-module and the top.
package result_drain_pkg;

  localparam int OUT_WIDTH_DEF  = 16;
  localparam int ROW_A_DEF      = 4;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int RES_DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } drain_state_t;

  // Index width for n items; never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_drain_if.sv
// Element stream carrying drained results: valid/ready handshake with a last marker.
// The producer drives s_valid/s_data/s_last and holds them while s_ready is low.
interface result_drain_if
  import result_drain_pkg::*;
#(
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) ();

  logic                 s_valid;
  logic [OUT_WIDTH-1:0] s_data;
  logic                 s_last;
  logic                 s_ready;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/result_buf.sv
// Result word storage: one write port, one registered read port, contents never reset.
// Read latency 1 cycle; a same-cycle write to the read address returns the old word.
module result_buf
  import result_drain_pkg::*;
#(
  parameter int WORD_W = OUT_WIDTH_DEF * ROW_A_DEF,
  parameter int DEPTH  = RES_DEPTH_DEF,
  parameter int AW     = idx_bits(RES_DEPTH_DEF)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/result_drain.sv
// Stores result words from the compute engine and streams words 0..len-1 lane by lane.
// First element 2 cycles after drain_start; one element per handshake, held stable while s_ready is low.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int ROW_A      = ROW_A_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RES_DEPTH  = RES_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          deload_out,
  input  logic [ADDR_WIDTH-1:0]         addr_res,
  input  logic [OUT_WIDTH*ROW_A-1:0]    out,
  input  logic                          drain_start,
  input  logic [$clog2(RES_DEPTH):0]    drain_len,
  result_drain_if.master                strm,
  output logic                          busy,
  output logic [$clog2(RES_DEPTH):0]    wr_count,
  output logic                          addr_err
);

  localparam int WORD_W = OUT_WIDTH * ROW_A;
  localparam int LEN_W  = $clog2(RES_DEPTH) + 1;
  localparam int PTR_W  = idx_bits(RES_DEPTH);
  localparam int LANE_W = idx_bits(ROW_A);

  localparam logic [LEN_W-1:0]      DEPTH_L   = LEN_W'(RES_DEPTH);
  localparam logic [ADDR_WIDTH:0]   DEPTH_A   = (ADDR_WIDTH + 1)'(RES_DEPTH);
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(ROW_A - 1);

  drain_state_t        state;
  drain_state_t        state_nxt;

  logic [LEN_W-1:0]    word_ptr;
  logic [LEN_W-1:0]    len_q;
  logic [LANE_W-1:0]   lane_cnt;
  logic [WORD_W-1:0]   lanes;
  logic [WORD_W-1:0]   rd_data;

  logic                wr_ok;
  logic                start_ok;
  logic                hs;
  logic                lane_end;
  logic                word_end;
  logic                next_word;
  logic                rd_en;
  logic [PTR_W-1:0]    rd_addr;

  assign wr_ok     = deload_out && ({1'b0, addr_res} < DEPTH_A);
  assign hs        = strm.s_valid && strm.s_ready;
  assign lane_end  = (lane_cnt == LAST_LANE);
  assign word_end  = (word_ptr == (len_q - LEN_W'(1)));
  assign next_word = hs && lane_end && !word_end;

  assign strm.s_valid = (state == ST_SEND);
  assign strm.s_data  = lanes[OUT_WIDTH-1:0];
  assign strm.s_last  = (state == ST_SEND) && lane_end && word_end;
  assign busy         = (state != ST_IDLE);

  result_buf #(
    .WORD_W (WORD_W),
    .DEPTH  (RES_DEPTH),
    .AW     (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (PTR_W'(addr_res)),
    .wr_data (out),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The read is launched one cycle ahead so the word is waiting when FETCH loads the lanes.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      ST_IDLE: begin
        if (drain_start && (drain_len != '0)) begin
          start_ok  = 1'b1;
          rd_en     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (hs && lane_end) begin
          if (word_end) begin
            state_nxt = ST_IDLE;
          end else begin
            rd_en     = 1'b1;
            rd_addr   = PTR_W'(word_ptr + LEN_W'(1));
            state_nxt = ST_FETCH;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_ptr <= '0;
      len_q    <= '0;
      lane_cnt <= '0;
      lanes    <= '0;
    end else begin
      if (start_ok) begin
        word_ptr <= '0;
        len_q    <= (drain_len > DEPTH_L) ? DEPTH_L : drain_len;
      end else if (next_word) begin
        word_ptr <= word_ptr + LEN_W'(1);
      end

      if (state == ST_FETCH) begin
        lanes    <= rd_data;
        lane_cnt <= '0;
      end else if (hs) begin
        lanes    <= lanes >> OUT_WIDTH;
        lane_cnt <= lane_cnt + LANE_W'(1);
      end
    end
  end

  // A write landing in the same cycle as an accepted start is the first of the new count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
      addr_err <= 1'b0;
    end else begin
      if (start_ok) begin
        wr_count <= wr_ok ? LEN_W'(1) : '0;
      end else if (wr_ok && (wr_count != DEPTH_L)) begin
        wr_count <= wr_count + LEN_W'(1);
      end

      if (deload_out && !wr_ok) begin
        addr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: a scoreboard queue holds expected stream elements,
// filled from a word model when a drain is started and consumed on every handshake.
module tb_result_drain;

  localparam int OW = 16;
  localparam int RA = 4;
  localparam int AW = 8;
  localparam int RD = 16;
  localparam int LW = 5;
  localparam int WW = OW * RA;

  logic          clk = 1'b0;
  logic          reset;
  logic          deload_out;
  logic [AW-1:0] addr_res;
  logic [WW-1:0] out_w;
  logic          drain_start;
  logic [LW-1:0] drain_len;
  logic          busy;
  logic [LW-1:0] wr_count;
  logic          addr_err;

  always #5 clk = ~clk;

  result_drain_if #(.OUT_WIDTH(OW)) strm_if ();

  result_drain #(
    .OUT_WIDTH  (OW),
    .ROW_A      (RA),
    .ADDR_WIDTH (AW),
    .RES_DEPTH  (RD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .deload_out  (deload_out),
    .addr_res    (addr_res),
    .out         (out_w),
    .drain_start (drain_start),
    .drain_len   (drain_len),
    .strm        (strm_if),
    .busy        (busy),
    .wr_count    (wr_count),
    .addr_err    (addr_err)
  );

  int            n_cmp = 0;
  int            n_err = 0;
  int            n_pop = 0;
  logic [WW-1:0] model [RD];
  logic [OW:0]   exp_q [$];
  logic          prev_stall = 1'b0;
  logic          prev_last  = 1'b0;
  logic [OW-1:0] prev_data  = '0;
  logic          last_hs    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs just before a rising edge, with this cycle's s_ready already driven.
  task automatic check_pre();
    logic [OW:0] e;
    if (prev_stall && strm_if.s_valid) begin
      check("hold_data", 32'(strm_if.s_data), 32'(prev_data));
      check("hold_last", 32'(strm_if.s_last), 32'(prev_last));
    end
    if (strm_if.s_valid && strm_if.s_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_elem", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        n_pop++;
        check("s_data", 32'(strm_if.s_data), 32'(e[OW-1:0]));
        check("s_last", 32'(strm_if.s_last), 32'(e[OW]));
        if (strm_if.s_last) last_hs = 1'b1;
      end
    end
    prev_stall = strm_if.s_valid && !strm_if.s_ready;
    prev_data  = strm_if.s_data;
    prev_last  = strm_if.s_last;
  endtask

  task automatic check_post();
    if (last_hs) begin
      check("busy_after_last", 32'(busy), 32'd0);
      last_hs = 1'b0;
    end
  endtask

  task automatic clk_step();
    #1;
    check_pre();
    @(posedge clk);
    #1;
    check_post();
    @(negedge clk);
  endtask

  function automatic logic [WW-1:0] pat(input int w);
    logic [WW-1:0] r;
    for (int k = 0; k < RA; k++) begin
      r[k*OW +: OW] = (w < 4) ? OW'(k + 4 * w) : OW'(32'hA000 + w * 16 + k);
    end
    return r;
  endfunction

  task automatic write_word(input int w, input logic [WW-1:0] d);
    deload_out = 1'b1;
    addr_res   = AW'(w);
    out_w      = d;
    clk_step();
    deload_out = 1'b0;
    if (w < RD) model[w] = d;
  endtask

  task automatic push_drain(input int len);
    int n;
    n = (len > RD) ? RD : len;
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < RA; k++) begin
        exp_q.push_back({((w == n - 1) && (k == RA - 1)), model[w][k*OW +: OW]});
      end
    end
  endtask

  task automatic start_drain(input int len);
    drain_start = 1'b1;
    drain_len   = LW'(len);
    clk_step();
    drain_start = 1'b0;
  endtask

  task automatic run_drain(input bit toggle, input int limit);
    int i;
    i = 0;
    while (busy && (i < limit)) begin
      if (toggle) strm_if.s_ready = (i % 2 == 0);
      clk_step();
      i++;
    end
    check("drain_done", 32'(busy), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    strm_if.s_ready = 1'b1;
  endtask

  initial begin
    int            cnt_before;
    int            target;
    int            i_wait;
    logic [WW-1:0] new_w;

    reset           = 1'b0;
    deload_out      = 1'b0;
    addr_res        = '0;
    out_w           = '0;
    drain_start     = 1'b0;
    drain_len       = '0;
    strm_if.s_ready = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_s_valid", 32'(strm_if.s_valid), 32'd0);
    check("rst_s_last", 32'(strm_if.s_last), 32'd0);
    check("rst_s_data", 32'(strm_if.s_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Fill every word, then confirm the write counter saturates.
    for (int w = 4; w < RD; w++) write_word(w, pat(w));
    for (int w = 0; w < 4; w++) write_word(w, pat(w));
    check("wr_count_full", 32'(wr_count), 32'd16);
    write_word(5, pat(5));
    check("wr_count_sat", 32'(wr_count), 32'd16);

    // Basic drain of words 0..3 with s_ready held high.
    push_drain(4);
    start_drain(4);
    check("valid_in_fetch", 32'(strm_if.s_valid), 32'd0);
    check("busy_started", 32'(busy), 32'd1);
    check("wr_count_cleared", 32'(wr_count), 32'd0);
    clk_step();
    check("valid_latency", 32'(strm_if.s_valid), 32'd1);
    run_drain(1'b0, 100);

    // Same drain with a stalling consumer.
    push_drain(4);
    start_drain(4);
    run_drain(1'b1, 200);

    // Out-of-range write.
    check("addr_err_clear", 32'(addr_err), 32'd0);
    cnt_before = 32'(wr_count);
    write_word(20, {WW{1'b1}});
    check("addr_err_set", 32'(addr_err), 32'd1);
    check("wr_count_oor", 32'(wr_count), 32'(cnt_before));
    repeat (3) clk_step();
    check("addr_err_sticky", 32'(addr_err), 32'd1);
    push_drain(5);
    start_drain(5);
    run_drain(1'b0, 100);

    // Zero-length start is ignored.
    start_drain(0);
    check("len0_ignored", 32'(busy), 32'd0);

    // A start while busy does not disturb the drain in flight.
    push_drain(2);
    start_drain(2);
    clk_step();
    clk_step();
    start_drain(4);
    run_drain(1'b0, 100);

    // Oversized length clamps; a write alongside the accepted start counts as one.
    push_drain(31);
    drain_start = 1'b1;
    drain_len   = LW'(31);
    deload_out  = 1'b1;
    addr_res    = AW'(15);
    out_w       = model[15];
    clk_step();
    drain_start = 1'b0;
    deload_out  = 1'b0;
    check("wr_count_start_wr", 32'(wr_count), 32'd1);
    run_drain(1'b0, 300);

    // Reset while lane 2 of word 1 is on the bus.
    push_drain(4);
    target = n_pop + 6;
    start_drain(4);
    i_wait = 0;
    while ((n_pop < target) && (i_wait < 100)) begin
      clk_step();
      i_wait++;
    end
    check("reached_lane2", 32'(n_pop), 32'(target));
    check("pre_reset_data", 32'(strm_if.s_data), 32'(model[1][2*OW +: OW]));
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(strm_if.s_valid), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    prev_stall = 1'b0;
    last_hs    = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_drain(4);
    start_drain(4);
    run_drain(1'b0, 100);

    // Write to word 0 during its FETCH: old word out now, new word next time.
    new_w = 64'h1111_2222_3333_4444;
    push_drain(1);
    start_drain(1);
    deload_out = 1'b1;
    addr_res   = '0;
    out_w      = new_w;
    clk_step();
    deload_out = 1'b0;
    model[0]   = new_w;
    run_drain(1'b0, 100);
    push_drain(1);
    start_drain(1);
    run_drain(1'b0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
